// File: rtl/multi_lights_selector.sv
// N-channel RGB lights selector. Each channel keeps a 3-bit colour code that
// steps on its own button press or on a shared auto-advance tick. The code is
// decoded to {R,G,B} and muxed by a global mode onto registered light outputs.
module multi_lights_selector #(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned CW     = 8,
  parameter int unsigned PERIOD = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             mode,
  input  logic [N_CH-1:0]        button,
  output logic [N_CH*3*CW-1:0]   light,
  output logic [N_CH*3-1:0]      colour
);

  localparam int unsigned CH_W  = 3 * CW;
  localparam int unsigned CNT_W = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERIOD - 1);

  localparam logic [1:0] MODE_WHITE  = 2'b00;
  localparam logic [1:0] MODE_STATIC = 2'b01;
  localparam logic [1:0] MODE_AUTO   = 2'b10;
  localparam logic [1:0] MODE_OFF    = 2'b11;

  logic [N_CH-1:0]       button_q;
  logic [N_CH-1:0]       press;
  logic [N_CH-1:0]       step;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_next;
  logic                  tick;
  logic [1:0]            mode_q;
  logic [N_CH*3-1:0]     colour_next;
  logic [N_CH*3*CW-1:0]  light_next;

  // Colour sequence: 001..110 cycle; 000 and 111 both enter at 001.
  function automatic logic [2:0] next_code(input logic [2:0] code);
    if (code == 3'd0 || code >= 3'd6) begin
      return 3'd1;
    end
    return 3'(code + 3'd1);
  endfunction

  // Rising-edge detect, auto-advance tick and next tick count.
  always_comb begin
    press    = button & ~button_q;
    tick     = (mode == MODE_AUTO) && (cnt == CNT_MAX);
    cnt_next = '0;
    if (mode == MODE_AUTO && !tick) begin
      cnt_next = CNT_W'(cnt + 1'b1);
    end
  end

  // Per-channel step decision; press and tick together still give one step.
  always_comb begin
    step        = '0;
    colour_next = colour;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (mode == MODE_STATIC) begin
        step[i] = press[i];
      end else if (mode == MODE_AUTO) begin
        step[i] = press[i] | tick;
      end
      if (step[i]) begin
        colour_next[3*i +: 3] = next_code(colour[3*i +: 3]);
      end
    end
  end

  // Light mux from the registered mode and current codes (one-cycle lag).
  always_comb begin
    light_next = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      case (mode_q)
        MODE_WHITE:  light_next[i*CH_W +: CH_W] = '1;
        MODE_STATIC,
        MODE_AUTO:   light_next[i*CH_W +: CH_W] = {{CW{colour[3*i+2]}},
                                                   {CW{colour[3*i+1]}},
                                                   {CW{colour[3*i]}}};
        default:     light_next[i*CH_W +: CH_W] = '0;
      endcase
    end
  end

  // State and output registers; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      button_q <= '0;
      cnt      <= '0;
      mode_q   <= MODE_OFF;
      colour   <= '0;
      light    <= '0;
    end else begin
      button_q <= button;
      cnt      <= cnt_next;
      mode_q   <= mode;
      colour   <= colour_next;
      light    <= light_next;
    end
  end

endmodule

// File: tb/tb_multi_lights_selector.sv
// Self-checking bench for multi_lights_selector (2 channels, 8-bit, period 4).
module tb_multi_lights_selector;

  localparam int unsigned N_CH   = 2;
  localparam int unsigned CW     = 8;
  localparam int unsigned PERIOD = 4;
  localparam int unsigned LW     = N_CH * 3 * CW;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      mode;
  logic [N_CH-1:0] button;
  logic [LW-1:0]   light;
  logic [N_CH*3-1:0] colour;

  int n_vec = 0;
  int n_bad = 0;

  multi_lights_selector #(.N_CH(N_CH), .CW(CW), .PERIOD(PERIOD)) dut (
    .clk    (clk),
    .rst    (rst),
    .mode   (mode),
    .button (button),
    .light  (light),
    .colour (colour)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: colour sequence as a table, tick from the length of the
  // current run of AUTO edges, light from the mode and codes one edge earlier.
  int              seq_next [8] = '{1, 2, 3, 4, 5, 6, 1, 1};
  int              m_code   [N_CH];
  logic [N_CH-1:0] m_prev_btn = '0;
  int              m_auto_run = 0;
  int              m_prev_mode = 3;
  logic [LW-1:0]   m_light = '0;
  logic [N_CH*3-1:0] m_colour = '0;

  function automatic logic [LW-1:0] expect_light(input int md, input logic [N_CH*3-1:0] codes);
    logic [LW-1:0] v;
    logic [2:0]    c;
    v = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      c = codes[3*i +: 3];
      if (md == 0) begin
        v[i*24 +: 24] = 24'hFFFFFF;
      end else if (md == 1 || md == 2) begin
        v[i*24 +: 24] = {(c[2] ? 8'hFF : 8'h00), (c[1] ? 8'hFF : 8'h00), (c[0] ? 8'hFF : 8'h00)};
      end
    end
    return v;
  endfunction

  initial begin
    for (int i = 0; i < int'(N_CH); i++) m_code[i] = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int i = 0; i < int'(N_CH); i++) m_code[i] = 0;
        m_prev_btn  = '0;
        m_auto_run  = 0;
        m_prev_mode = 3;
        m_light     = '0;
        m_colour    = '0;
      end else begin
        bit tk;
        m_light = expect_light(m_prev_mode, m_colour);
        tk = (mode == 2'd2) && ((m_auto_run % PERIOD) == PERIOD - 1);
        for (int i = 0; i < int'(N_CH); i++) begin
          bit pr;
          pr = button[i] && !m_prev_btn[i];
          if ((mode == 2'd1 && pr) || (mode == 2'd2 && (pr || tk)))
            m_code[i] = seq_next[m_code[i]];
          m_colour[3*i +: 3] = 3'(m_code[i]);
        end
        m_prev_btn  = button;
        m_auto_run  = (mode == 2'd2) ? m_auto_run + 1 : 0;
        m_prev_mode = int'(mode);
      end
    end
  end

  // Continuous comparison against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      check("light_model", 64'(light), 64'(m_light));
      check("colour_model", 64'(colour), 64'(m_colour));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [2:0]  exp_c [7] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b001};
  logic [23:0] exp_l [7] = '{24'h0000FF, 24'h00FF00, 24'h00FFFF, 24'hFF0000,
                             24'hFF00FF, 24'hFFFF00, 24'h0000FF};

  initial begin
    rst = 1'b1; mode = 2'b01; button = '0;
    repeat (2) cyc();
    check("rst_light", 64'(light), 64'h0);
    check("rst_colour", 64'(colour), 64'h0);
    rst = 1'b0;
    repeat (3) cyc();
    check("black_light", 64'(light), 64'h0);

    // Single-cycle presses on channel 0 in STATIC.
    for (int k = 0; k < 7; k++) begin
      button = 2'b01;
      cyc();
      check("static_colour0", 64'(colour[2:0]), 64'(exp_c[k]));
      check("static_colour1", 64'(colour[5:3]), 64'h0);
      button = 2'b00;
      cyc();
      check("static_light0", 64'(light[23:0]), 64'(exp_l[k]));
      check("static_light1", 64'(light[47:24]), 64'h0);
    end

    // Held button steps exactly once.
    button = 2'b10;
    repeat (10) cyc();
    check("held_colour", 64'(colour), 64'(6'b001_001));
    button = 2'b00;
    cyc();

    // AUTO: tick on the 4th edge, coincident press gives a single step.
    mode = 2'b10;
    repeat (3) cyc();
    check("auto_pre_tick", 64'(colour), 64'(6'b001_001));
    button = 2'b01;
    cyc();
    check("auto_tick_press", 64'(colour), 64'(6'b010_010));
    button = 2'b00;
    repeat (3) cyc();
    check("auto_hold", 64'(colour), 64'(6'b010_010));
    cyc();
    check("auto_tick2", 64'(colour), 64'(6'b011_011));

    // WHITE, OFF, then back to STATIC.
    mode = 2'b00;
    repeat (2) cyc();
    check("white_light", 64'(light), 64'hFFFF_FFFF_FFFF);
    button = 2'b11;
    cyc();
    button = 2'b00;
    cyc();
    check("white_ignore", 64'(colour), 64'(6'b011_011));
    mode = 2'b11;
    repeat (2) cyc();
    check("off_light", 64'(light), 64'h0);
    mode = 2'b01;
    repeat (2) cyc();
    check("restore_light", 64'(light), 64'h00FFFF_00FFFF);

    // Async reset mid-AUTO with cnt=2 and codes 011/101.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      button = (k < 3) ? 2'b11 : 2'b10;
      cyc();
      button = 2'b00;
      cyc();
    end
    check("setup_codes", 64'(colour), 64'(6'b101_011));
    mode = 2'b10;
    repeat (2) cyc();
    check("mid_auto_codes", 64'(colour), 64'(6'b101_011));
    #3 rst = 1'b1;
    #1;
    check("async_light", 64'(light), 64'h0);
    check("async_colour", 64'(colour), 64'h0);
    cyc();
    rst = 1'b0;
    repeat (3) cyc();
    check("post_rst_no_tick", 64'(colour), 64'h0);
    cyc();
    check("post_rst_tick", 64'(colour), 64'(6'b001_001));

    // Randomised traffic against the model.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(7) == 0) mode = 2'($urandom_range(3));
      for (int i = 0; i < int'(N_CH); i++)
        if ($urandom_range(2) == 0) button[i] = ~button[i];
      rst = ($urandom_range(80) == 0);
      cyc();
    end
    rst = 1'b0;
    repeat (2) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
